// File: rtl/cnn_pkg.sv
// Shared constants for the CNN front end: default load sizes and loader state encoding.
// The compute core sizes its weight/data RAMs from the same defaults.
package cnn_pkg;

   localparam int W_BYTES_DEF = 54;  // 2 layers x 3 kernels x 3x3
   localparam int D_BYTES_DEF = 64;  // 8x8 frame, row-major

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOAD_W   = 2'd1;
   localparam logic [1:0] ST_LOAD_D   = 2'd2;
   localparam logic [1:0] ST_WAIT_RES = 2'd3;

   function automatic logic is_load_state(input logic [1:0] s);
      return (s == ST_LOAD_W) || (s == ST_LOAD_D);
   endfunction

endpackage

// File: rtl/cnn_frame_loader.sv
// Streams weight and image bytes into the compute core RAMs, then waits for the
// core's result flag. The byte count is authoritative; an early s_last aborts the phase.
module cnn_frame_loader
   import cnn_pkg::*;
#(
   parameter int W_BYTES     = W_BYTES_DEF,
   parameter int D_BYTES     = D_BYTES_DEF,
   parameter int RES_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   input  logic       reuse_w,
   output logic       mode,
   output logic       ram_en,
   output logic [7:0] din,
   input  logic       out_data_flag,
   output logic       frame_done,
   output logic       err,
   output logic       w_held
);

   localparam int TMR_W = $clog2(RES_TIMEOUT + 1);

   logic [1:0]       state;
   logic [7:0]       cnt;
   logic [TMR_W-1:0] tmr;
   logic             acc;
   logic             last_byte;

   assign s_ready = is_load_state(state);
   assign acc     = s_valid & s_ready;

   always_comb begin
      last_byte = 1'b0;
      if (state == ST_LOAD_W) last_byte = (cnt == 8'(W_BYTES - 1));
      else                    last_byte = (cnt == 8'(D_BYTES - 1));
   end

   // RAM write port is registered one cycle behind acceptance; reset suppresses
   // the write of a byte accepted in the reset cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         tmr        <= '0;
         ram_en     <= 1'b0;
         mode       <= 1'b0;
         din        <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
         w_held     <= 1'b0;
      end else begin
         ram_en     <= acc;
         frame_done <= 1'b0;
         err        <= 1'b0;
         if (acc) begin
            din  <= s_data;
            mode <= (state == ST_LOAD_D);
         end
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               tmr <= '0;
               if (s_valid) state <= (reuse_w && w_held) ? ST_LOAD_D : ST_LOAD_W;
            end
            ST_LOAD_W: begin
               if (acc) begin
                  if (last_byte) begin
                     state  <= ST_LOAD_D;
                     cnt    <= '0;
                     w_held <= 1'b1;
                  end else if (s_last) begin
                     state  <= ST_IDLE;
                     cnt    <= '0;
                     err    <= 1'b1;
                     w_held <= 1'b0;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            ST_LOAD_D: begin
               if (acc) begin
                  if (last_byte) begin
                     state <= ST_WAIT_RES;
                     cnt   <= '0;
                     tmr   <= '0;
                  end else if (s_last) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                     err   <= 1'b1;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            ST_WAIT_RES: begin
               // A result flag in the final timeout cycle still counts as success.
               if (out_data_flag) begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b1;
               end else if (tmr == TMR_W'(RES_TIMEOUT - 1)) begin
                  state <= ST_IDLE;
                  err   <= 1'b1;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Directed bench for cnn_frame_loader: full frames, weight reuse, early s_last,
// result timeout, input gaps and reset in the middle of a data phase.
module tb_cnn_frame_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_last;
   logic       s_ready;
   logic       reuse_w;
   logic       mode;
   logic       ram_en;
   logic [7:0] din;
   logic       out_data_flag;
   logic       frame_done;
   logic       err;
   logic       w_held;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int         lat_errs = 0;
   int         err_cnt  = 0;
   int         fd_cnt   = 0;
   logic       mon_on   = 1'b0;
   logic       acc_prev = 1'b0;
   logic       rst_prev = 1'b0;
   logic [7:0] data_prev = '0;

   always #5 clk = ~clk;

   cnn_frame_loader dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .reuse_w      (reuse_w),
      .mode         (mode),
      .ram_en       (ram_en),
      .din          (din),
      .out_data_flag(out_data_flag),
      .frame_done   (frame_done),
      .err          (err),
      .w_held       (w_held)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // Write-port monitor: each write must follow its acceptance by exactly one cycle.
   always @(negedge clk) begin
      if (mon_on) begin
         logic exp_en;
         exp_en = acc_prev && !rst_prev;
         if (ram_en !== exp_en) lat_errs++;
         else if (exp_en && din !== data_prev) lat_errs++;
         if (ram_en === 1'b1) got_q.push_back({mode, din});
         if (err === 1'b1) err_cnt++;
         if (frame_done === 1'b1) fd_cnt++;
         acc_prev  = s_valid && s_ready;
         data_prev = s_data;
         rst_prev  = rst;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic last, input logic md);
      logic ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk);
         #2;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      else     exp_q.push_back({md, d});
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_phase(input int n, input logic [7:0] start, input logic md,
                             input logic gap, input int last_idx);
      for (int i = 0; i < n; i++) begin
         send_byte(start + 8'(i), (i == last_idx), md);
         if (gap) begin
            @(posedge clk);
            #2;
         end
      end
   endtask

   task automatic wait_frame_done();
      logic seen;
      seen = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      out_data_flag = 1'b1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = (frame_done === 1'b1);
      end
      if (!seen) chk("frame_done_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #2;
      out_data_flag = 1'b0;
   endtask

   task automatic end_test(input string nm, input int n_err, input int n_fd, input logic wh);
      int n;
      repeat (3) @(posedge clk);
      #2;
      chk({nm, ".nwr"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({nm, ".wr"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
      chk({nm, ".latency"}, lat_errs, 0);
      chk({nm, ".err"}, err_cnt, n_err);
      chk({nm, ".frame_done"}, fd_cnt, n_fd);
      chk({nm, ".w_held"}, {31'd0, w_held}, {31'd0, wh});
      got_q.delete();
      exp_q.delete();
      lat_errs = 0;
      err_cnt  = 0;
      fd_cnt   = 0;
   endtask

   initial begin
      int n;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      reuse_w = 1'b0; out_data_flag = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.s_ready", {31'd0, s_ready}, 0);
      chk("rst.ram_en", {31'd0, ram_en}, 0);
      chk("rst.mode", {31'd0, mode}, 0);
      chk("rst.din", {24'd0, din}, 0);
      chk("rst.frame_done", {31'd0, frame_done}, 0);
      chk("rst.err", {31'd0, err}, 0);
      chk("rst.w_held", {31'd0, w_held}, 0);
      @(posedge clk);
      #2;
      rst    = 1'b0;
      mon_on = 1'b1;

      // Result flag while idle must be ignored.
      out_data_flag = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      out_data_flag = 1'b0;
      end_test("idle_flag", 0, 0, 1'b0);

      // Full frame with weight load.
      send_phase(54, 8'h01, 1'b0, 1'b0, 53);
      send_phase(64, 8'h40, 1'b1, 1'b0, 63);
      wait_frame_done();
      end_test("full", 0, 1, 1'b1);

      // Weight reuse: data phase only.
      reuse_w = 1'b1;
      send_phase(64, 8'h80, 1'b1, 1'b0, 63);
      wait_frame_done();
      end_test("reuse", 0, 1, 1'b1);

      // Early s_last on weight byte 10.
      reuse_w = 1'b0;
      send_phase(10, 8'hA0, 1'b0, 1'b0, 9);
      @(negedge clk);
      chk("early.err_pulse", {31'd0, err}, 1);
      chk("early.s_ready", {31'd0, s_ready}, 0);
      chk("early.w_held_now", {31'd0, w_held}, 0);
      @(posedge clk);
      #2;
      end_test("early", 1, 0, 1'b0);

      // Timeout: result flag held low.
      send_phase(54, 8'h10, 1'b0, 1'b0, 53);
      send_phase(64, 8'h50, 1'b1, 1'b0, 63);
      n = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (err === 1'b1) break;
         n++;
      end
      chk("timeout.cycles", n, 255);
      @(posedge clk);
      #2;
      end_test("timeout", 1, 0, 1'b1);

      // Alternating s_valid gaps, no s_last at all.
      send_phase(54, 8'h20, 1'b0, 1'b1, -1);
      send_phase(64, 8'h60, 1'b1, 1'b1, -1);
      wait_frame_done();
      end_test("gaps", 0, 1, 1'b1);

      // Reset on data byte 30, with that byte offered in the reset cycle.
      reuse_w = 1'b1;
      send_phase(29, 8'hC0, 1'b1, 1'b0, -1);
      s_valid = 1'b1;
      s_data  = 8'hDD;
      rst     = 1'b1;
      @(posedge clk);
      #2;
      rst     = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk("rstmid.ram_en", {31'd0, ram_en}, 0);
      chk("rstmid.s_ready", {31'd0, s_ready}, 0);
      chk("rstmid.w_held", {31'd0, w_held}, 0);
      @(posedge clk);
      #2;
      end_test("rstmid", 0, 0, 1'b0);

      // Recovery frame after the mid-phase reset.
      reuse_w = 1'b0;
      send_phase(54, 8'h30, 1'b0, 1'b0, 53);
      send_phase(64, 8'h70, 1'b1, 1'b0, 63);
      wait_frame_done();
      end_test("recover", 0, 1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
